// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI4-Stream packet sink.
// Buffers accepted beats in a small FIFO for a downstream consumer and checks
// each packet: data must increment by one from beat to beat, packets may not
// exceed MAX_BEATS, and every byte must be kept and strobed. Completed packets
// are counted and errors are held in sticky flags.
// Optional build macro AXIS_PKT_SINK_ID_CHECK_EN adds a TID/TDEST consistency
// check and the ERR_ID output.
module axis_pkt_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic        ACLK,
  input  logic        RST,
  input  logic        TVALID,
  output logic        TREADY,
  input  logic [31:0] TDATA,
  input  logic [3:0]  TKEEP,
  input  logic [3:0]  TSTRB,
  input  logic        TLAST,
  input  logic [7:0]  TID,
  input  logic [1:0]  TDEST,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic        OUT_LAST,
  input  logic        CLR_ERR,
  output logic [15:0] PKT_CNT,
  output logic        ERR_SEQ,
  output logic        ERR_LEN,
  output logic        ERR_KEEP
`ifdef AXIS_PKT_SINK_ID_CHECK_EN
  ,
  output logic        ERR_ID
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BEAT_ONE  = CW'(1);
  localparam logic [CW-1:0] BEAT_MAX  = CW'(MAX_BEATS);
  localparam logic [CW-1:0] BEAT_SAT  = CW'(MAX_BEATS + 1);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  // ---------------- ingress FIFO ----------------
  beat_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;

  assign push      = TVALID & TREADY;
  assign OUT_VALID = (count != '0);
  assign pop       = OUT_VALID & OUT_READY;
  // Head is forced to zero when empty so the outputs never show stale storage.
  assign OUT_DATA  = OUT_VALID ? mem[rptr].data : 32'd0;
  assign OUT_LAST  = OUT_VALID ? mem[rptr].last : 1'b0;

  // Next occupancy; push and pop together cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Beat storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge ACLK) begin
    if (!RST && push) mem[wptr] <= '{data: TDATA, last: TLAST};
  end

  // Pointers, occupancy and the registered ready (looks at next occupancy).
  always_ff @(posedge ACLK) begin
    if (RST) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      TREADY <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count  <= count_nxt;
      TREADY <= (count_nxt < DEPTH_C);
    end
  end

  // ---------------- packet checker ----------------
  state_t        state;
  logic [31:0]   exp_data;
  logic [CW-1:0] beats, beats_nxt;
  logic          first;
  logic          seq_ev, len_ev, keep_ev;

  assign first     = (state == IDLE);
  assign beats_nxt = first ? BEAT_ONE :
                     (beats == BEAT_SAT) ? beats : beats + BEAT_ONE;
  assign seq_ev    = push & ~first & (TDATA != exp_data);
  assign len_ev    = push & (beats_nxt > BEAT_MAX);
  assign keep_ev   = push & ((TKEEP != 4'hF) | (TSTRB != TKEEP));

  // Packet FSM, beat counter, expected data, packet count and sticky errors.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state    <= IDLE;
      exp_data <= '0;
      beats    <= '0;
      PKT_CNT  <= '0;
      ERR_SEQ  <= 1'b0;
      ERR_LEN  <= 1'b0;
      ERR_KEEP <= 1'b0;
    end else begin
      if (push) begin
        exp_data <= TDATA + 32'd1;
        beats    <= beats_nxt;
        state    <= TLAST ? IDLE : IN_PKT;
        if (TLAST) PKT_CNT <= PKT_CNT + 16'd1;
      end
      // A new error in the clearing cycle keeps the flag set.
      ERR_SEQ  <= (ERR_SEQ  & ~CLR_ERR) | seq_ev;
      ERR_LEN  <= (ERR_LEN  & ~CLR_ERR) | len_ev;
      ERR_KEEP <= (ERR_KEEP & ~CLR_ERR) | keep_ev;
    end
  end

`ifdef AXIS_PKT_SINK_ID_CHECK_EN
  logic [7:0] pkt_tid;
  logic [1:0] pkt_tdest;
  logic       id_ev;

  assign id_ev = push & ~first & ((TID != pkt_tid) | (TDEST != pkt_tdest));

  // Capture the packet's routing on its first beat, flag later disagreement.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      pkt_tid   <= '0;
      pkt_tdest <= '0;
      ERR_ID    <= 1'b0;
    end else begin
      if (push && first) begin
        pkt_tid   <= TID;
        pkt_tdest <= TDEST;
      end
      ERR_ID <= (ERR_ID & ~CLR_ERR) | id_ev;
    end
  end
`else
  logic unused_id;
  assign unused_id = ^{TID, TDEST};
`endif

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Bench for axis_pkt_sink: queue-level reference model with a per-cycle
// compare process, plus directed scenarios with literal expectations.
module tb_axis_pkt_sink;
  localparam int DEPTH = 4;
  localparam int MAXB  = 16;

  logic        ACLK = 1'b0;
  logic        RST = 1'b1;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic [31:0] TDATA = '0;
  logic [3:0]  TKEEP = 4'hF;
  logic [3:0]  TSTRB = 4'hF;
  logic        TLAST = 1'b0;
  logic [7:0]  TID = '0;
  logic [1:0]  TDEST = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_DATA;
  logic        OUT_LAST;
  logic        CLR_ERR = 1'b0;
  logic [15:0] PKT_CNT;
  logic        ERR_SEQ, ERR_LEN, ERR_KEEP;
`ifdef AXIS_PKT_SINK_ID_CHECK_EN
  logic        ERR_ID;
`endif

  axis_pkt_sink #(.FIFO_DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
    .ACLK(ACLK), .RST(RST), .TVALID(TVALID), .TREADY(TREADY),
    .TDATA(TDATA), .TKEEP(TKEEP), .TSTRB(TSTRB), .TLAST(TLAST),
    .TID(TID), .TDEST(TDEST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .CLR_ERR(CLR_ERR),
    .PKT_CNT(PKT_CNT), .ERR_SEQ(ERR_SEQ), .ERR_LEN(ERR_LEN), .ERR_KEEP(ERR_KEEP)
`ifdef AXIS_PKT_SINK_ID_CHECK_EN
    , .ERR_ID(ERR_ID)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic        l;
  } mb_t;

  mb_t         q[$];
  bit          chk_en = 0;
  bit          m_rdy, m_inpkt;
  logic [31:0] m_prev;
  int          m_beats;
  logic [15:0] m_pkt;
  bit          m_eseq, m_elen, m_ekeep, m_eid;
  logic [7:0]  m_tid;
  logic [1:0]  m_tdest;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;

  always @(posedge ACLK) begin
    bit  acc, pp, ev_s, ev_l, ev_k, ev_i;
    mb_t b;
    cyc++;
    if (TVALID && TREADY) begin
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (RST) begin
      q.delete();
      chk_en = 1; m_rdy = 0; m_inpkt = 0; m_prev = '0; m_beats = 0; m_pkt = '0;
      m_eseq = 0; m_elen = 0; m_ekeep = 0; m_eid = 0; m_tid = '0; m_tdest = '0;
    end else if (chk_en) begin
      acc = TVALID && m_rdy;
      pp  = (q.size() > 0) && OUT_READY;
      ev_s = 0; ev_l = 0; ev_k = 0; ev_i = 0;
      if (pp) void'(q.pop_front());
      if (acc) begin
        b.d = TDATA; b.l = TLAST;
        q.push_back(b);
        if (!m_inpkt) begin
          m_beats = 1; m_tid = TID; m_tdest = TDEST;
        end else begin
          m_beats++;
          if (TDATA != m_prev + 32'd1) ev_s = 1;
          if (TID != m_tid || TDEST != m_tdest) ev_i = 1;
        end
        if (m_beats > MAXB) ev_l = 1;
        if (TKEEP != 4'hF || TSTRB != TKEEP) ev_k = 1;
        m_prev = TDATA;
        m_inpkt = !TLAST;
        if (TLAST) m_pkt = m_pkt + 16'd1;
      end
      m_eseq  = (m_eseq  && !CLR_ERR) || ev_s;
      m_elen  = (m_elen  && !CLR_ERR) || ev_l;
      m_ekeep = (m_ekeep && !CLR_ERR) || ev_k;
      m_eid   = (m_eid   && !CLR_ERR) || ev_i;
      m_rdy   = q.size() < DEPTH;
    end
  end

  // Compare every cycle, mid-period, once the model has seen reset.
  always @(negedge ACLK) begin
    if (chk_en) begin
      chk("TREADY",    32'(TREADY),    32'(m_rdy));
      chk("OUT_VALID", 32'(OUT_VALID), 32'(q.size() > 0));
      chk("OUT_DATA",  OUT_DATA,       (q.size() > 0) ? q[0].d : 32'd0);
      chk("OUT_LAST",  32'(OUT_LAST),  (q.size() > 0) ? 32'(q[0].l) : 32'd0);
      chk("PKT_CNT",   32'(PKT_CNT),   32'(m_pkt));
      chk("ERR_SEQ",   32'(ERR_SEQ),   32'(m_eseq));
      chk("ERR_LEN",   32'(ERR_LEN),   32'(m_elen));
      chk("ERR_KEEP",  32'(ERR_KEEP),  32'(m_ekeep));
`ifdef AXIS_PKT_SINK_ID_CHECK_EN
      chk("ERR_ID",    32'(ERR_ID),    32'(m_eid));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic l, input logic [3:0] k,
                       input logic [3:0] s, input logic [7:0] id);
    TDATA = d; TLAST = l; TKEEP = k; TSTRB = s; TID = id; TDEST = 2'd1;
    TVALID = 1'b1;
  endtask

  // Hold the driven beat until it is accepted, bounded.
  task automatic wait_accept();
    bit got;
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge ACLK);
      got = TREADY;
      @(posedge ACLK);
      #1;
      if (got) done = 1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no handshake expected handshake within 64 cycles");
    end
    TVALID = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    drive(d, l, 4'hF, 4'hF, 8'h05);
    wait_accept();
  endtask

  task automatic do_reset();
    TVALID = 1'b0; CLR_ERR = 1'b0;
    RST = 1'b1;
    step();
    step();
    chk("rst_TREADY",    32'(TREADY),    32'd0);
    chk("rst_OUT_VALID", 32'(OUT_VALID), 32'd0);
    chk("rst_OUT_DATA",  OUT_DATA,       32'd0);
    chk("rst_PKT_CNT",   32'(PKT_CNT),   32'd0);
    chk("rst_ERRS",      32'({ERR_SEQ, ERR_LEN, ERR_KEEP}), 32'd0);
    RST = 1'b0;
    step();
    chk("rst_release_TREADY", 32'(TREADY), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0;

    // Clean 4-beat packet, consumer always ready.
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h10 + 32'(i), i == 3);
      chk("s1_out_valid", 32'(OUT_VALID), 32'd1);
      chk("s1_out_data",  OUT_DATA, 32'h10 + 32'(i));
    end
    step();
    chk("s1_pkt_cnt", 32'(PKT_CNT), 32'd1);
    chk("s1_errs", 32'({ERR_SEQ, ERR_LEN, ERR_KEEP}), 32'd0);

    // Backpressure: FIFO fills after 4 beats, 5th waits for a pop.
    do_reset();
    OUT_READY = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), 1'b0);
    chk("s2_tready_full", 32'(TREADY), 32'd0);
    drive(32'h34, 1'b1, 4'hF, 4'hF, 8'h05);
    step(); step(); step();
    chk("s2_acc_cnt", 32'(acc_cnt), 32'd4);
    chk("s2_tready_held", 32'(TREADY), 32'd0);
    OUT_READY = 1'b1;
    c0 = cyc;
    wait_accept();
    chk("s2_fifth_acc_cycle", 32'(last_acc_cyc), 32'(c0 + 2));
    for (int i = 0; i < 6; i++) step();
    chk("s2_pkt_cnt", 32'(PKT_CNT), 32'd1);
    chk("s2_drained", 32'(OUT_VALID), 32'd0);

    // Sequence break 0x21 -> 0x23, then clear.
    do_reset();
    send(32'h20, 1'b0);
    send(32'h21, 1'b0);
    send(32'h23, 1'b1);
    step();
    chk("s3_err_seq", 32'(ERR_SEQ), 32'd1);
    chk("s3_pkt_cnt", 32'(PKT_CNT), 32'd1);
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("s3_err_seq_clr", 32'(ERR_SEQ), 32'd0);

    // Over-length packet: error on beat 17, count on beat 18.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(32'h100 + 32'(i), 1'b0);
      if (i == 15) chk("s4_len_beat16", 32'(ERR_LEN), 32'd0);
      if (i == 16) chk("s4_len_beat17", 32'(ERR_LEN), 32'd1);
    end
    send(32'h111, 1'b1);
    step();
    chk("s4_pkt_cnt", 32'(PKT_CNT), 32'd1);
    chk("s4_seq_ok", 32'(ERR_SEQ), 32'd0);

    // Reset mid-packet, then a clean packet.
    do_reset();
    OUT_READY = 1'b0;
    send(32'h40, 1'b0);
    send(32'h41, 1'b0);
    RST = 1'b1;
    step();
    chk("s5_fifo_empty", 32'(OUT_VALID), 32'd0);
    chk("s5_tready", 32'(TREADY), 32'd0);
    RST = 1'b0;
    step();
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h50 + 32'(i), i == 3);
    step();
    chk("s5_pkt_cnt", 32'(PKT_CNT), 32'd1);
    chk("s5_errs", 32'({ERR_SEQ, ERR_LEN, ERR_KEEP}), 32'd0);

    // Keep/strobe errors, with an error landing on a clear cycle.
    do_reset();
    drive(32'h70, 1'b1, 4'h7, 4'h7, 8'h05);
    wait_accept();
    chk("s6_keep_err", 32'(ERR_KEEP), 32'd1);
    CLR_ERR = 1'b1;
    drive(32'h71, 1'b1, 4'hF, 4'hE, 8'h05);
    wait_accept();
    CLR_ERR = 1'b0;
    chk("s6_strb_err_wins", 32'(ERR_KEEP), 32'd1);
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("s6_keep_clr", 32'(ERR_KEEP), 32'd0);
    chk("s6_pkt_cnt", 32'(PKT_CNT), 32'd2);

`ifdef AXIS_PKT_SINK_ID_CHECK_EN
    // TID changes mid-packet.
    do_reset();
    drive(32'h60, 1'b0, 4'hF, 4'hF, 8'h05);
    wait_accept();
    drive(32'h61, 1'b1, 4'hF, 4'hF, 8'h06);
    wait_accept();
    step();
    chk("s7_err_id", 32'(ERR_ID), 32'd1);
    chk("s7_seq_ok", 32'(ERR_SEQ), 32'd0);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_pkt_sink.md
AXIS_PKT_SINK -- requirements
Module: axis_pkt_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the ingress buffer depth in beats (power of two, 2..16).
REQ-002 SHALL have parameter MAX_BEATS, default 16, giving the maximum legal beats per packet.
REQ-003 SHALL have the following ports; the clock and reset are listed first.
- ACLK  in  1  single clock, all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- TVALID  in  1  AXI4-Stream beat valid from the upstream stream generator.
- TREADY  out  1  beat accepted when TVALID and TREADY are both high at a rising edge.
- TDATA  in  32  beat payload.
- TKEEP  in  4  byte keep.
- TSTRB  in  4  byte strobe.
- TLAST  in  1  last beat of a packet.
- TID  in  8  stream ID.
- TDEST  in  2  destination.
- OUT_VALID  out  1  buffered beat available.
- OUT_READY  in  1  consumer pops a beat when OUT_VALID and OUT_READY are both high.
- OUT_DATA  out  32  head-of-buffer TDATA.
- OUT_LAST  out  1  head-of-buffer TLAST.
- CLR_ERR  in  1  clears the sticky error flags.
- PKT_CNT  out  16  count of completed packets, wrapping modulo 2^16.
- ERR_SEQ  out  1  sticky data-sequence error.
- ERR_LEN  out  1  sticky packet-length error.
- ERR_KEEP  out  1  sticky keep/strobe error.

Function
REQ-004 SHALL drive TREADY as a register equal to (occupancy < FIFO_DEPTH); TREADY SHALL have no combinational path from TVALID.
REQ-005 SHALL write {TDATA, TLAST} into the FIFO on each accepted beat; that beat SHALL first appear on OUT_VALID/OUT_DATA one cycle after acceptance (latency 1).
REQ-006 SHALL apply a simultaneous push and pop in the same cycle, leaving occupancy unchanged; a pop with occupancy 0 SHALL be impossible because OUT_VALID is low.
REQ-007 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so that full and empty are distinct.
REQ-008 SHALL implement a checker FSM with two states:
- IDLE: on an accepted beat with TLAST=0, go to IN_PKT; on an accepted beat with TLAST=1, stay in IDLE, increment PKT_CNT and treat the beat as a single-beat packet.
- IN_PKT: on an accepted beat with TLAST=1, go to IDLE and increment PKT_CNT.
REQ-009 SHALL latch TDATA as the expected base on the first beat of a packet; each later beat SHALL require TDATA == previous TDATA + 1 (32-bit, wrapping), and a mismatch SHALL set ERR_SEQ.
REQ-010 SHALL count beats within a packet with a saturating counter; an accepted beat that makes the count exceed MAX_BEATS SHALL set ERR_LEN, and the FSM SHALL remain in IN_PKT until TLAST.
REQ-011 SHALL set ERR_KEEP on any accepted beat where TKEEP != 4'hF or TSTRB != TKEEP.
REQ-012 SHALL keep the error flags sticky; CLR_ERR SHALL clear them on the next edge, and an error event in the same cycle as CLR_ERR SHALL win, leaving the flag set.
REQ-013 SHALL apply all checks only on accepted beats; TVALID with TREADY low SHALL have no effect.

Reset
REQ-014 SHALL on RST high at a rising edge:
- set TREADY=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, PKT_CNT=0 and all ERR_* flags to 0;
- empty the FIFO and put the FSM in IDLE;
- release TREADY to 1 on the first edge after RST goes low.
REQ-015 SHALL discard any partially received packet when RST asserts mid-packet; no error SHALL be flagged for it.

Configuration
REQ-016 SHALL, when macro AXIS_PKT_SINK_ID_CHECK_EN is defined, latch TID and TDEST on the first beat of a packet and set sticky ERR_ID on any later beat of that packet whose TID or TDEST differs; ERR_ID is cleared by CLR_ERR and reset, like the other error flags.
REQ-017 SHALL, without AXIS_PKT_SINK_ID_CHECK_EN, omit the ERR_ID port and its logic, and ignore TID and TDEST.

Verification
REQ-018 Bench SHALL cover the following scenarios:
- 4-beat packet TDATA 0x10..0x13, TLAST on beat 4, OUT_READY=1 -> PKT_CNT=1, no errors, OUT_DATA sequence 0x10..0x13 each one cycle after acceptance.
- OUT_READY=0 with 5 beats offered and FIFO_DEPTH=4 -> TREADY low after 4 accepts; fifth beat accepted the cycle after OUT_READY goes to 1.
- Beats 0x20, 0x21, 0x23 with TLAST on the third -> ERR_SEQ=1, PKT_CNT=1; then CLR_ERR pulse -> ERR_SEQ=0.
- 17 beats without TLAST (MAX_BEATS=16) -> ERR_LEN set on beat 17; TLAST on beat 18 -> PKT_CNT increments.
- RST pulsed after beat 2 of a 4-beat packet -> all outputs reset, FIFO empty; next clean packet -> PKT_CNT=1, no errors.
- With AXIS_PKT_SINK_ID_CHECK_EN defined: TID changes from 0x05 to 0x06 mid-packet -> ERR_ID=1.
